// File: rtl/uart_mem_if.sv
// uart_mem bus interface: request/ready slave port of the UART peripheral.
interface uart_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    enable;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    bus_err;

    modport master (
        output enable, wr_en, addr, i_data, be,
        input  ready, o_data, bus_err
    );

    modport slave (
        input  enable, wr_en, addr, i_data, be,
        output ready, o_data, bus_err
    );
endinterface

// File: rtl/uart_mem.sv
// uart_mem: memory-mapped 8N1 UART with baud divisor, RX/TX path and irq.
// Define UART_MEM_FIFO_EN for 16-entry FIFOs; otherwise 1-byte holding regs.
module uart_mem_fifo #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [2**PW];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (do_pop)  rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module uart_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_mem_if.slave bus,
    output logic     irq,
    output logic     tx_pin,
    input  logic     rx_pin
);
`ifdef UART_MEM_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {B_IDLE, B_DONE, B_WAIT} bus_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    bus_state_t b_state, b_nxt;
    rx_state_t  rx_state, rx_nxt;

    logic [15:0] baud, baud_eff, half;
    logic [1:0]  int_en, int_pend, int_set, int_clr;
    logic        txe_q, rxr_q, tx_idle, rx_rdy;

    logic                  be_ok, legal, access, wr, rd;
    logic [2:0]            sel_idx;
    logic                  s_bl, s_bh, s_st, s_da, s_ie, s_pe;
    logic [DATA_WIDTH-1:0] raw, mask, rd_q;
    logic                  err_q;

    logic [7:0] tx_byte, rx_byte;
    logic       txf_empty, txf_full, rxf_empty, rxf_full;
    logic       tx_busy, tx_tick, tx_last, tx_load;
    logic [9:0] tx_sh;
    logic [3:0] tx_bit;
    logic [15:0] tx_cnt;

    logic        rx_m, rx_s, rx_p, rx_fall, rx_tick, rx_push;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;

    // Address decode and access qualification
    assign be_ok   = (bus.be == BW'(4'h1)) || (bus.be == BW'(4'h3)) ||
                     (bus.be == BW'(4'hF));
    assign legal   = be_ok && (bus.addr[1:0] == 2'b00) &&
                     (bus.addr <= ADDR_WIDTH'('h14));
    assign access  = (b_state == B_IDLE) && bus.enable;
    assign wr      = access && legal && bus.wr_en;
    assign rd      = access && legal && !bus.wr_en;
    assign sel_idx = bus.addr[4:2];
    assign s_bl    = (sel_idx == 3'd0);
    assign s_bh    = (sel_idx == 3'd1);
    assign s_st    = (sel_idx == 3'd2);
    assign s_da    = (sel_idx == 3'd3);
    assign s_ie    = (sel_idx == 3'd4);
    assign s_pe    = (sel_idx == 3'd5);

    always_comb begin
        raw  = '0;
        mask = '0;
        unique case (1'b1)
            s_bl:    raw = DATA_WIDTH'(baud);
            s_bh:    raw = DATA_WIDTH'(baud[15:8]);
            s_st:    raw = DATA_WIDTH'({txf_full, rx_rdy});
            s_da:    raw = rxf_empty ? '0 : DATA_WIDTH'(rx_byte);
            s_ie:    raw = DATA_WIDTH'(int_en);
            s_pe:    raw = DATA_WIDTH'(int_pend);
            default: raw = '0;
        endcase
        for (int i = 0; i < BW; i++) mask[i*8 +: 8] = {8{bus.be[i]}};
    end

    always_comb begin
        b_nxt = b_state;
        unique case (b_state)
            B_IDLE:  if (bus.enable) b_nxt = B_DONE;
            B_DONE:  b_nxt = B_WAIT;
            B_WAIT:  if (!bus.enable) b_nxt = B_IDLE;
            default: b_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state <= B_IDLE;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            b_state <= b_nxt;
            if (access) begin
                err_q <= !legal;
                rd_q  <= rd ? (raw & mask) : '0;
            end
        end
    end

    assign bus.ready   = (b_state == B_DONE);
    assign bus.o_data  = bus.ready ? rd_q : '0;
    assign bus.bus_err = bus.ready && err_q;

    // Control registers; pending bits latch rising edges, set beats W1C
    assign tx_idle  = !tx_busy && txf_empty;
    assign rx_rdy   = !rxf_empty;
    assign int_set  = {tx_idle & ~txe_q, rx_rdy & ~rxr_q};
    assign int_clr  = (wr && s_pe) ? bus.i_data[1:0] : 2'b00;
    assign irq      = |(int_pend & int_en);
    assign baud_eff = (baud == 16'd0) ? 16'd1 : baud;
    assign half     = (baud_eff - 16'd1) >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud     <= 16'd434;
            int_en   <= 2'b00;
            int_pend <= 2'b00;
            txe_q    <= 1'b1;
            rxr_q    <= 1'b0;
        end else begin
            if (wr && s_bl) begin
                baud[7:0] <= bus.i_data[7:0];
                if (bus.be[1]) baud[15:8] <= bus.i_data[15:8];
            end
            if (wr && s_bh) baud[15:8] <= bus.i_data[7:0];
            if (wr && s_ie) int_en <= bus.i_data[1:0];
            int_pend <= (int_pend & ~int_clr) | int_set;
            txe_q    <= tx_idle;
            rxr_q    <= rx_rdy;
        end
    end

    uart_mem_fifo #(.DEPTH(DEPTH)) u_txf (
        .clk(clk), .rst_n(rst_n),
        .push(wr && s_da), .wdata(bus.i_data[7:0]),
        .pop(tx_load), .rdata(tx_byte),
        .empty(txf_empty), .full(txf_full)
    );

    uart_mem_fifo #(.DEPTH(DEPTH)) u_rxf (
        .clk(clk), .rst_n(rst_n),
        .push(rx_push), .wdata(rx_sh),
        .pop(rd && s_da), .rdata(rx_byte),
        .empty(rxf_empty), .full(rxf_full)
    );

    // Transmitter: back-to-back frames when the queue holds another byte
    assign tx_tick = (tx_cnt == baud_eff - 16'd1);
    assign tx_last = tx_busy && tx_tick && (tx_bit == 4'd9);
    assign tx_load = !txf_empty && (!tx_busy || tx_last);
    assign tx_pin  = tx_busy ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (tx_load) begin
            tx_busy <= 1'b1;
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (tx_busy) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                tx_bit <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // Receiver
    assign rx_fall = rx_p && !rx_s;
    assign rx_tick = (rx_cnt == baud_eff - 16'd1);
    assign rx_push = (rx_state == R_STOP) && rx_tick && rx_s && !rxf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_comb begin
        rx_nxt = rx_state;
        unique case (rx_state)
            R_IDLE:  if (rx_fall) rx_nxt = R_START;
            R_START: if (rx_cnt == half) rx_nxt = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nxt = R_STOP;
            R_STOP:  if (rx_tick) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_nxt;
            if (rx_state == R_IDLE || rx_nxt != rx_state || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 16'd1;
            if (rx_state == R_START) rx_bit <= '0;
            if (rx_state == R_DATA && rx_tick) begin
                rx_sh  <= {rx_s, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_mem.sv
// tb_uart_mem: directed vector table plus loopback, irq and reset sequences.
module tb_uart_mem;
    logic clk = 1'b0;
    logic rst_n;
    logic irq, tx_pin, rx_pin;

    always #5 clk = ~clk;

    uart_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    assign rx_pin = tx_pin;

    uart_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .irq(irq), .tx_pin(tx_pin), .rx_pin(rx_pin)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vt[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rdata, output logic err);
        bit got;
        got   = 1'b0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk);
        #1;
        bus.enable = 1'b1;
        bus.wr_en  = w;
        bus.addr   = a;
        bus.i_data = d;
        bus.be     = b;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got   = 1'b1;
                rdata = bus.o_data;
                err   = bus.bus_err;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL ready_timeout: addr %h got no ready expected ready", a);
        end
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(negedge clk);
        check("ready_err_after", {30'b0, bus.ready, bus.bus_err}, 32'h0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        logic [31:0] r;
        logic e;
        access(1'b1, a, d, b, r, e);
        check("wr_err", {31'b0, e}, 32'h0);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        access(1'b0, a, 32'h0, b, r, e);
        check(nm, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic e;
        bus.enable = 1'b0;
        bus.wr_en  = 1'b0;
        bus.addr   = '0;
        bus.i_data = '0;
        bus.be     = '0;
        rst_n      = 1'b0;

        vt.push_back('{1'b0, 32'h00, 32'h0,      4'h3, 32'h1B2, 1'b0});
        vt.push_back('{1'b1, 32'h00, 32'h1B2,    4'h3, 32'h0,   1'b0});
        vt.push_back('{1'b0, 32'h00, 32'h0,      4'h3, 32'h1B2, 1'b0});
        vt.push_back('{1'b1, 32'h00, 32'hB2,     4'h1, 32'h0,   1'b0});
        vt.push_back('{1'b1, 32'h04, 32'h01,     4'h1, 32'h0,   1'b0});
        vt.push_back('{1'b0, 32'h00, 32'h0,      4'h1, 32'hB2,  1'b0});
        vt.push_back('{1'b0, 32'h04, 32'h0,      4'h1, 32'h01,  1'b0});
        vt.push_back('{1'b0, 32'h00, 32'h0,      4'hF, 32'h1B2, 1'b0});
        vt.push_back('{1'b1, 32'h01, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h03, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h01, 32'hFFFFFFFF, 4'h3, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h16, 32'hFFFFFFFF, 4'h3, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h15, 32'hFFFFFFFF, 4'h1, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h18, 32'h0,      4'h1, 32'h0,   1'b1});
        vt.push_back('{1'b1, 32'h00, 32'h0,      4'h5, 32'h0,   1'b1});
        vt.push_back('{1'b0, 32'h00, 32'h0,      4'h3, 32'h1B2, 1'b0});
        vt.push_back('{1'b0, 32'h08, 32'h0,      4'hF, 32'h0,   1'b0});
        vt.push_back('{1'b0, 32'h10, 32'h0,      4'h1, 32'h0,   1'b0});
        vt.push_back('{1'b0, 32'h14, 32'h0,      4'h1, 32'h0,   1'b0});
        vt.push_back('{1'b1, 32'h08, 32'hFF,     4'h1, 32'h0,   1'b0});
        vt.push_back('{1'b0, 32'h08, 32'h0,      4'h1, 32'h0,   1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_bus_err", {31'b0, bus.bus_err}, 32'h0);
        check("rst_o_data", bus.o_data, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_tx_pin", {31'b0, tx_pin}, 32'h1);

        foreach (vt[i]) begin
            access(vt[i].wr, vt[i].a, vt[i].d, vt[i].be, r, e);
            check($sformatf("vec%0d_data", i), r, vt[i].exp);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].err});
        end

        rd_chk("lb_status0", 32'h08, 4'h1, 32'h0);
        wr_reg(32'h0C, 32'hAA, 4'h1);
        repeat (100 + 15 * 434) @(posedge clk);
        rd_chk("lb_status1", 32'h08, 4'h1, 32'h1);
        rd_chk("lb_data", 32'h0C, 4'h1, 32'hAA);
        rd_chk("lb_status2", 32'h08, 4'h1, 32'h0);
        rd_chk("lb_empty_data", 32'h0C, 4'h1, 32'h0);
        rd_chk("lb_pend", 32'h14, 4'h1, 32'h3);

        wr_reg(32'h10, 32'h3, 4'h1);
        check("irq_on", {31'b0, irq}, 32'h1);
        wr_reg(32'h14, 32'h3, 4'h1);
        check("irq_off", {31'b0, irq}, 32'h0);
        rd_chk("pend_clr", 32'h14, 4'h1, 32'h0);

        wr_reg(32'h0C, 32'hAA, 4'h1);
        repeat (100 + 15 * 434) @(posedge clk);
        check("irq_frame", {31'b0, irq}, 32'h1);
        rd_chk("pend_frame", 32'h14, 4'h1, 32'h3);
        wr_reg(32'h14, 32'h3, 4'h1);
        check("irq_frame_off", {31'b0, irq}, 32'h0);
        rd_chk("pend_frame_clr", 32'h14, 4'h1, 32'h0);
        rd_chk("irq_data", 32'h0C, 4'h1, 32'hAA);

        wr_reg(32'h00, 32'h32, 4'h3);
        wr_reg(32'h10, 32'h1, 4'h1);
        wr_reg(32'h0C, 32'h00, 4'h1);
        repeat (75) @(posedge clk);
        #2;
        check("mid_tx_low", {31'b0, tx_pin}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'b0, tx_pin}, 32'h1);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_ready", {31'b0, bus.ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_baud", 32'h00, 4'h3, 32'h1B2);
        rd_chk("post_rst_inten", 32'h10, 4'h1, 32'h0);
        rd_chk("post_rst_pend", 32'h14, 4'h1, 32'h0);
        rd_chk("post_rst_status", 32'h08, 4'h1, 32'h0);
        check("post_rst_tx", {31'b0, tx_pin}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_mem.md
# uart_mem

Memory-mapped 8N1 UART peripheral with a simple request/ready bus slave, baud divisor registers, RX/TX data path and edge-triggered interrupts. It sits on the CPU peripheral bus, drives `tx_pin`, samples `rx_pin`, and raises `irq` to the interrupt controller.

## Interface
- `ADDR_WIDTH`, 32: bus address width.
- `DATA_WIDTH`, 32: bus data width; `be` width is `DATA_WIDTH/8`.

- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: request valid; the master holds it until `ready`.
- `wr_en` in 1: 1 = write, 0 = read.
- `addr` in ADDR_WIDTH: byte address.
- `i_data` in DATA_WIDTH: write data.
- `be` in DATA_WIDTH/8: byte enables.
- `ready` out 1: one-cycle completion pulse.
- `o_data` out DATA_WIDTH: read data, valid while `ready`=1, otherwise 0.
- `irq` out 1: `|(int_pending & int_enable)`.
- `bus_err` out 1: asserted only together with `ready` on an illegal access.
- `tx_pin` out 1: serial out, idle high.
- `rx_pin` in 1: serial in; synchronised by two flops.

## Operation
- Register map (word-aligned offsets). Only byte lane 0 is meaningful; unused bits read 0.
  - 0x00 BAUD_L: baud[7:0]. Lane 1 at 0x00 aliases baud[15:8], so a 16-bit access at 0x00 covers the whole divisor.
  - 0x04 BAUD_H: baud[15:8].
  - 0x08 STATUS (RO): bit0 RX_READY (RX data available); bit1 TX_FULL. Writes are ignored.
  - 0x0C DATA: a write pushes a TX byte, and the byte is dropped silently if TX is full. A read pops an RX byte, and returns 0 if RX is empty.
  - 0x10 INT_EN: bit0 RX_READY, bit1 TX_EMPTY.
  - 0x14 INT_PENDING: reads return the pending bits. Writing 1 clears a bit (W1C).
- Legal `be` values are 0001, 0011 and 1111. Legal accesses require `addr[1:0]`=0 and `addr` ≤ 0x14.
- Anything else is an error: `ready`=1 and `bus_err`=1, no side effects, `o_data`=0. Examples: 32-bit at 0x1/0x2/0x3, 16-bit at 0x1, any access at 0x15/0x16/0x18.
- Pending bits:
  - bit0 is set on the rising edge of "RX byte available".
  - bit1 is set on the rising edge of "transmitter idle with TX empty".
  - Bits are set regardless of INT_EN.
  - A set event in the same cycle as a W1C clear wins.
  - Level conditions that persist after a clear do not re-set the bit.
- Baud: `baud` = clk cycles per bit. 0 is treated as 1.
- TX frame: start (0), 8 data bits LSB-first, stop (1). The next byte starts immediately if queued.
- RX: detect start falling edge, verify at half a bit, sample data bits at mid-bit.
  - A bad stop bit discards the byte.
  - A byte arriving when RX is full is dropped.

## Timing
- Reset values:
  - `ready`=0, `bus_err`=0, `o_data`=0, `irq`=0, `tx_pin`=1.
  - baud=434, INT_EN=0, INT_PENDING=0, FIFOs empty.
- Bus FSM states:
  - IDLE → DONE when `enable`=1 is sampled; the access is performed on that edge.
  - DONE drives `ready` (and `bus_err` if illegal) for exactly one cycle.
  - DONE → WAIT. WAIT → IDLE once `enable`=0.
  - Each `enable` assertion performs exactly one access, so a DATA read never double-pops.
- Latency: `ready` rises on the clock edge after `enable` is first sampled high.
- A TX byte completes 10·baud cycles after it starts. Its RX_READY appears within about 10.5·baud cycles after TX start.

## Configuration
- `UART_MEM_FIFO_EN` defined: 16-entry TX and RX FIFOs. TX_FULL means 16 entries; RX_READY means the RX FIFO is non-empty.
- Not defined: single-byte TX and RX holding registers. TX_FULL means the holding register is occupied; the byte moves to the shifter as soon as it is idle.

## Test plan
- 16-bit write of 434 to 0x00 (be 0011), then read back → 0x000001B2. Byte writes 0xB2→0x00 and 0x01→0x04, then byte reads → 0xB2 and 0x01.
- Writes with (addr, be) = (1,1111), (2,1111), (3,1111), (1,0011), (0x18,1111), (0x16,0011), (0x15,0001) → `ready` with `bus_err`=1. `bus_err`=0 on the following cycle.
- Loopback `tx_pin`→`rx_pin`:
  - STATUS reads 0.
  - Write 0xAA to DATA and wait 100+15·434 cycles → STATUS bit0=1.
  - DATA read returns 0xAA, then STATUS reads 0.
- After the previous test, write INT_EN=0x3 → `irq`=1. W1C 0x3 to 0x14 → `irq`=0 and INT_PENDING reads 0.
- Send 0xAA with both interrupts enabled and wait one frame → `irq`=1. W1C 0x3 → `irq`=0 and pending reads 0. A DATA read still returns 0xAA.
- Assert `rst_n` low mid-frame → `tx_pin`=1 at once and all registers return to reset values.
